// File: rtl/bcd_count99_pkg.sv
// Shared types and constants for the two-digit BCD counter and its button debouncer.
package bcd_count99_pkg;

    // Largest legal value of one BCD digit
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] digit_t;

    // Debouncer states: a settled level, or a candidate level being confirmed
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

endpackage

// File: rtl/bcd_count99_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability FSM, one-cycle press pulse.
module btn_debounce
    import bcd_count99_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1, s2;
    db_state_t     state, state_nxt;
    logic [CW-1:0] cnt;
    logic          done;

    // The entering sample already counts as the first differing one
    assign done = (cnt >= CNT_LAST);

    // Two-flop synchronizer on the raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= STABLE_LO;
        else        state <= state_nxt;
    end

    // Next-state: any sample back at the old level aborts the candidate
    always_comb begin
        state_nxt = state;
        case (state)
            STABLE_LO: if (s2)  state_nxt = WAIT_HI;
            WAIT_HI:   if (!s2) state_nxt = STABLE_LO;
                       else if (done) state_nxt = STABLE_HI;
            STABLE_HI: if (!s2) state_nxt = WAIT_LO;
            WAIT_LO:   if (s2)  state_nxt = STABLE_HI;
                       else if (done) state_nxt = STABLE_LO;
            default:   state_nxt = STABLE_LO;
        endcase
    end

    // Stability counter: counts consecutive differing samples while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nxt == WAIT_HI || state_nxt == WAIT_LO) begin
            cnt <= (state_nxt == state) ? cnt + 1'b1 : CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Output: pulse only on a confirmed press, never on release
    always_comb begin
        pulse = (state == WAIT_HI) && (state_nxt == STABLE_HI);
    end

endmodule

// File: rtl/bcd_count99.sv
// Two-digit BCD up/down counter (00..99) advanced by a prescaler tick or a debounced button.
module bcd_count99
    import bcd_count99_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   up_dn,
    input  logic   clr,
    input  logic   btn_step,
    output digit_t units,
    output digit_t tens,
    output logic   wrap
);

    localparam int            DIV      = CLK_HZ / TICK_HZ;
    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;
    logic          tick, step, adv;
    digit_t        units_nxt, tens_nxt;
    logic          wrap_nxt;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_step),
        .pulse (step)
    );

    // Terminal-count tick; frozen prescaler never ticks
    assign tick = en && (pre == PRE_LAST);
    // A tick and a step in the same cycle merge into one advance
    assign adv  = tick || step;

    // Prescaler: free-runs while enabled, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  pre <= '0;
        else if (clr) pre <= '0;
        else if (en)  pre <= tick ? '0 : pre + 1'b1;
    end

    // Next digit values for one BCD step in the selected direction
    always_comb begin
        units_nxt = units;
        tens_nxt  = tens;
        wrap_nxt  = 1'b0;
        if (adv) begin
            if (up_dn) begin
                if (units >= BCD_MAX) begin
                    units_nxt = 4'd0;
                    if (tens >= BCD_MAX) begin
                        tens_nxt = 4'd0;
                        wrap_nxt = 1'b1;
                    end else begin
                        tens_nxt = tens + 4'd1;
                    end
                end else begin
                    units_nxt = units + 4'd1;
                end
            end else begin
                if (units == 4'd0) begin
                    units_nxt = BCD_MAX;
                    if (tens == 4'd0) begin
                        tens_nxt = BCD_MAX;
                        wrap_nxt = 1'b1;
                    end else begin
                        tens_nxt = tens - 4'd1;
                    end
                end else begin
                    units_nxt = units - 4'd1;
                end
            end
        end
    end

    // Digit and wrap registers; clear wins over any advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            units <= 4'd0;
            tens  <= 4'd0;
            wrap  <= 1'b0;
        end else if (clr) begin
            units <= 4'd0;
            tens  <= 4'd0;
            wrap  <= 1'b0;
        end else begin
            units <= units_nxt;
            tens  <= tens_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_count99.sv
// Bench for bcd_count99: constant vector table, directed corner sequences, random run vs. model.
module tb_bcd_count99;

    localparam int CLK_HZ = 10;
    localparam int TICK_HZ = 1;
    localparam int DB = 4;
    localparam int DIV = CLK_HZ / TICK_HZ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0, up_dn = 1'b1, clr = 1'b0, btn_step = 1'b0;
    logic [3:0] units, tens;
    logic       wrap;

    int total = 0;
    int passed = 0;

    // Reference model: count as an integer 0..99, debouncer as level + run length
    int m_val = 0, m_phase = 0, m_run = 0;
    bit m_wrap = 0, m_s1 = 0, m_s2 = 0, m_lv = 0;

    typedef struct {
        string nm;
        int    n;
        bit    en;
        bit    up;
        bit    clr;
        int    exp_val;
        bit    exp_wrap;
    } vec_t;
    vec_t tbl[9];

    bcd_count99 #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
        .btn_step(btn_step), .units(units), .tens(tens), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int ev, input bit ew);
        total++;
        if (tens == 4'(ev / 10) && units == 4'(ev % 10) && wrap == ew) passed++;
        else $display("FAIL %s: got %0d%0d wrap=%0b, expected %02d wrap=%0b",
                      nm, tens, units, wrap, ev, ew);
    endtask

    task automatic model_reset();
        m_val = 0; m_phase = 0; m_run = 0;
        m_wrap = 0; m_s1 = 0; m_s2 = 0; m_lv = 0;
    endtask

    // One clock: evaluate model from pre-edge inputs, clock, sample #1 later, compare
    task automatic cyc();
        bit pulse, tick, n_lv, n_wrap;
        int n_run, n_phase, n_val;
        pulse = 0; tick = 0; n_lv = m_lv; n_run = m_run;
        if (m_s2 != m_lv) begin
            n_run = m_run + 1;
            if (n_run == DB) begin
                n_lv = m_s2; n_run = 0; pulse = m_s2;
            end
        end else n_run = 0;
        n_phase = m_phase;
        if (clr) n_phase = 0;
        else if (en) begin
            if (m_phase == DIV - 1) begin tick = 1; n_phase = 0; end
            else n_phase = m_phase + 1;
        end
        n_val = m_val; n_wrap = 0;
        if (clr) n_val = 0;
        else if (tick || pulse) begin
            if (up_dn) begin n_wrap = (m_val == 99); n_val = (m_val + 1) % 100; end
            else       begin n_wrap = (m_val == 0);  n_val = (m_val + 99) % 100; end
        end
        @(posedge clk); #1;
        if (!rst_n) model_reset();
        else begin
            m_s2 = m_s1; m_s1 = btn_step;
            m_lv = n_lv; m_run = n_run; m_phase = n_phase;
            m_val = n_val; m_wrap = n_wrap;
        end
        check("model", m_val, m_wrap);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_clr();
        clr = 1; cyc(); clr = 0;
    endtask

    initial begin
        tbl[0] = '{"pre9",     9, 1, 1, 0,  0, 0};
        tbl[1] = '{"tick1",    1, 1, 1, 0,  1, 0};
        tbl[2] = '{"ten_ticks",90, 1, 1, 0, 10, 0};
        tbl[3] = '{"en_off",  50, 0, 1, 0, 10, 0};
        tbl[4] = '{"down1",   10, 1, 0, 0,  9, 0};
        tbl[5] = '{"down_to0",90, 1, 0, 0,  0, 0};
        tbl[6] = '{"wrap_dn", 10, 1, 0, 0, 99, 1};
        tbl[7] = '{"wrap_1cy", 1, 0, 0, 0, 99, 0};
        tbl[8] = '{"clr",      1, 0, 0, 1,  0, 0};

        // Reset state
        #2 rst_n = 0;
        #1 check("reset", 0, 0);
        run(2);
        rst_n = 1;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            en = tbl[i].en; up_dn = tbl[i].up; clr = tbl[i].clr;
            run(tbl[i].n);
            clr = 0;
            check(tbl[i].nm, tbl[i].exp_val, tbl[i].exp_wrap);
        end

        // Up wrap 99 -> 00, pulse lasts one cycle; then down wrap 00 -> 99
        en = 1; up_dn = 1; do_clr();
        run(990); check("up_99", 99, 0);
        run(10);  check("up_wrap", 0, 1);
        run(1);   check("up_wrap_end", 0, 0);
        up_dn = 0; do_clr();
        run(10);  check("dn_wrap", 99, 1);
        run(1);   check("dn_wrap_end", 99, 0);

        // Manual step: 6-cycle press steps once, 3-cycle glitch does not
        en = 0; up_dn = 1; do_clr();
        btn_step = 1; run(6); check("press_step", 1, 0);
        btn_step = 0; run(10); check("release", 1, 0);
        btn_step = 1; run(3);
        btn_step = 0; run(10); check("glitch", 1, 0);

        // Step pulse landing on the tick edge advances once
        en = 1; do_clr();
        run(4);
        btn_step = 1; run(6); check("tick_step", 1, 0);
        btn_step = 0; run(20); check("after_coinc", 3, 0);

        // Clear on the tick cycle at 47
        do_clr();
        run(470); check("at47", 47, 0);
        run(9); clr = 1; cyc(); clr = 0; check("clr_tick", 0, 0);
        run(9); check("clr_hold", 0, 0);
        run(1); check("clr_next", 1, 0);

        // Async reset mid-count at 63
        do_clr();
        run(633); check("at63", 63, 0);
        #2 rst_n = 0;
        #1 model_reset(); check("rst_mid_cnt", 0, 0);
        run(2); rst_n = 1;

        // Async reset mid-debounce: no step after release
        en = 0;
        btn_step = 1; run(5);
        btn_step = 0; #2 rst_n = 0;
        #1 model_reset(); check("rst_mid_db", 0, 0);
        run(2); rst_n = 1;
        run(20); check("no_spurious", 0, 0);

        // Random run against the model
        begin
            int hold = 0;
            for (int i = 0; i < 3000; i++) begin
                if (hold == 0) begin
                    btn_step = 1'($urandom_range(0, 1));
                    hold = $urandom_range(1, 8);
                end
                hold--;
                en    = ($urandom_range(0, 3) != 0);
                up_dn = 1'($urandom_range(0, 1));
                clr   = ($urandom_range(0, 39) == 0);
                cyc();
            end
            clr = 0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
